// File: rtl/soc_cpu_3_oci_pkg.sv
// soc_cpu_3_oci_pkg: shared defaults and state encoding for the trace symbol packer
package soc_cpu_3_oci_pkg;
  localparam int SYM_W_D = 2;
  localparam int SLOTS_D = 15;
  localparam int WORD_W = 30;
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/soc_cpu_3_oci_sat_counter.sv
// soc_cpu_3_oci_sat_counter: saturating up-counter with synchronous clear
module soc_cpu_3_oci_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value
);
  // count up on inc, holding at all-ones
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) value <= '0;
    else if (clear) value <= '0;
    else if (inc && value != '1) value <= value + 1'b1;
endmodule

// File: rtl/soc_cpu_3_oci_dct_packer.sv
// soc_cpu_3_oci_dct_packer: packs compressed-trace symbols into 30-bit words with a hold/handshake stage
module soc_cpu_3_oci_dct_packer
  import soc_cpu_3_oci_pkg::*;
#(
  parameter int SYM_W = SYM_W_D,
  parameter int SLOTS = SLOTS_D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym_data,
  input  logic              flush,
  output logic [WORD_W-1:0] dct_buffer,
  output logic [3:0]        dct_count,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [7:0]        drop_count
);
  state_t            state, state_nxt;
  logic [WORD_W-1:0] buf_nxt;
  logic [3:0]        cnt_nxt;
  logic              drop;

  // next word contents and state; a symbol arriving with word_ready starts the next word
  always_comb begin
    state_nxt = state;
    buf_nxt   = dct_buffer;
    cnt_nxt   = dct_count;
    drop      = 1'b0;
    if (state == FILL) begin
      if (sym_valid) begin
        buf_nxt = dct_buffer | (WORD_W'(sym_data) << (SYM_W * int'(dct_count)));
        cnt_nxt = dct_count + 4'd1;
      end
      if (cnt_nxt == 4'(SLOTS) || (flush && cnt_nxt != 4'd0)) state_nxt = HOLD;
    end else if (word_ready) begin
      state_nxt = FILL;
      buf_nxt   = sym_valid ? WORD_W'(sym_data) : '0;
      cnt_nxt   = {3'b000, sym_valid};
    end else begin
      drop = sym_valid;
    end
  end

  // word register and state; all outputs come straight from flops
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= FILL;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else begin
      state      <= state_nxt;
      dct_buffer <= buf_nxt;
      dct_count  <= cnt_nxt;
    end

  assign word_valid = (state == HOLD);

  soc_cpu_3_oci_sat_counter #(.W(8)) u_drop (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (drop),
    .clear   (1'b0),
    .value   (drop_count)
  );
endmodule

// File: tb/tb_soc_cpu_3_oci_dct_packer.sv
// tb_soc_cpu_3_oci_dct_packer: directed scoreboard bench for the trace symbol packer
module tb_soc_cpu_3_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset_n, sym_valid, flush, word_ready;
  logic [1:0]  sym_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        word_valid;
  logic [7:0]  drop_count;
  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];

  soc_cpu_3_oci_dct_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .flush      (flush),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic [1:0] d);
    sym_valid = 1'b1;
    sym_data  = d;
    tick();
    sym_valid = 1'b0;
  endtask

  // scoreboard monitor: every accepted word must match the oldest expected word
  always @(negedge clk)
    if (reset_n && word_valid && word_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %0h/%0d expected none", dct_buffer, dct_count);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({dct_buffer, dct_count} !== e) begin
          errors++;
          $display("FAIL word: got %0h/%0d expected %0h/%0d", dct_buffer, dct_count, e[33:4], e[3:0]);
        end
      end
    end

  initial begin
    reset_n = 1'b0; sym_valid = 1'b0; sym_data = '0; flush = 1'b0; word_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_count", 32'(dct_count), 0);
    chk("rst_buffer", 32'(dct_buffer), 0);
    chk("rst_drop", 32'(drop_count), 0);
    reset_n = 1'b1;
    tick();
    // full word of fifteen 2'b01 symbols
    exp_q.push_back({30'h15555555, 4'd15});
    for (int i = 0; i < 14; i++) sym(2'd1);
    chk("full_latency", 32'(word_valid), 0);
    sym(2'd1);
    chk("full_valid", 32'(word_valid), 1);
    chk("full_count", 32'(dct_count), 15);
    chk("full_buffer", 32'(dct_buffer), 32'h15555555);
    // held word with four dropped symbols
    sym_valid = 1'b1; sym_data = 2'd3;
    repeat (4) tick();
    sym_valid = 1'b0;
    chk("hold_buffer", 32'(dct_buffer), 32'h15555555);
    chk("hold_count", 32'(dct_count), 15);
    chk("hold_drop4", 32'(drop_count), 4);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("hold_flush_valid", 32'(word_valid), 1);
    chk("hold_flush_buffer", 32'(dct_buffer), 32'h15555555);
    // accept and start a new word with the same-cycle symbol
    word_ready = 1'b1;
    sym(2'd2);
    word_ready = 1'b0;
    chk("restart_valid", 32'(word_valid), 0);
    chk("restart_count", 32'(dct_count), 1);
    chk("restart_buffer", 32'(dct_buffer), 2);
    exp_q.push_back({30'h2, 4'd1});
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush1_valid", 32'(word_valid), 1);
    word_ready = 1'b1; tick(); word_ready = 1'b0;
    chk("drain_valid", 32'(word_valid), 0);
    // empty flush is ignored
    flush = 1'b1; tick(); flush = 1'b0;
    chk("empty_flush_valid", 32'(word_valid), 0);
    chk("empty_flush_count", 32'(dct_count), 0);
    // symbols 3,2,1 then flush: 3 | 2<<2 | 1<<4 = 27
    exp_q.push_back({30'd27, 4'd3});
    sym(2'd3); sym(2'd2); sym(2'd1);
    chk("partial_nohold", 32'(word_valid), 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("partial_valid", 32'(word_valid), 1);
    chk("partial_buffer", 32'(dct_buffer), 27);
    chk("partial_count", 32'(dct_count), 3);
    word_ready = 1'b1; tick(); word_ready = 1'b0;
    // symbol arriving with flush is packed first: 1 | 3<<2 = 13
    exp_q.push_back({30'd13, 4'd2});
    sym(2'd1);
    flush = 1'b1; sym(2'd3); flush = 1'b0;
    chk("symflush_valid", 32'(word_valid), 1);
    chk("symflush_buffer", 32'(dct_buffer), 13);
    // drop counter saturates
    sym_valid = 1'b1;
    repeat (300) tick();
    sym_valid = 1'b0;
    chk("drop_sat", 32'(drop_count), 255);
    chk("drop_sat_buffer", 32'(dct_buffer), 13);
    word_ready = 1'b1; tick(); word_ready = 1'b0;
    // asynchronous reset mid-word with seven symbols
    for (int i = 0; i < 7; i++) sym(2'd2);
    chk("mid_count", 32'(dct_count), 7);
    chk("mid_buffer", 32'(dct_buffer), 32'h2AAA);
    #2 reset_n = 1'b0;
    #1;
    chk("async_count", 32'(dct_count), 0);
    chk("async_buffer", 32'(dct_buffer), 0);
    chk("async_valid", 32'(word_valid), 0);
    chk("async_drop", 32'(drop_count), 0);
    #1 reset_n = 1'b1;
    sym(2'd3);
    chk("post_rst_count", 32'(dct_count), 1);
    chk("post_rst_buffer", 32'(dct_buffer), 3);
    repeat (2) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
